// File: rtl/fsic_io_serdes_rx.sv
// Receive deserializer for the io_serdes link: recovers pCLK_RATIO-bit words from the
// forwarded-clock serial stream and finds frame alignment by bit-slipping against a training word.
module fsic_io_serdes_rx #(
   parameter int                    pCLK_RATIO     = 4,
   parameter logic [pCLK_RATIO-1:0] pTRAIN_PATTERN = pCLK_RATIO'(1),
   parameter int                    pLOCK_CNT      = 4
) (
   input  logic                                 ioclk,
   input  logic                                 axis_rst_n,
   input  logic                                 serial_data_in,
   input  logic                                 link_active,
   input  logic                                 realign,
   output logic [pCLK_RATIO-1:0]                rxdata_out,
   output logic                                 rxdata_valid,
   output logic                                 rx_locked,
   output logic [$clog2(pCLK_RATIO)-1:0]        rx_phase
);

   localparam int PW = $clog2(pCLK_RATIO);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] TRAIN  = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam logic [PW-1:0] LAST_BIT = PW'(pCLK_RATIO - 1);
   localparam logic [7:0]    LOCK_MAX = 8'(pLOCK_CNT);

   logic [1:0]            state;
   logic [pCLK_RATIO-1:0] sr;
   logic [PW-1:0]         bit_cnt;
   logic [7:0]            match_cnt;
   logic                  slip_pend;
   logic [pCLK_RATIO-1:0] frame_word;
   logic                  boundary;

   // The word completed by this edge: the incoming bit becomes the MSB.
   assign frame_word = {serial_data_in, sr[pCLK_RATIO-1:1]};
   assign boundary   = link_active && (bit_cnt == LAST_BIT);

   // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
   always_ff @(posedge ioclk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state        <= IDLE;
         sr           <= '0;
         bit_cnt      <= '0;
         match_cnt    <= '0;
         slip_pend    <= 1'b0;
         rxdata_out   <= '0;
         rxdata_valid <= 1'b0;
         rx_locked    <= 1'b0;
         rx_phase     <= '0;
      end else begin
         rxdata_valid <= 1'b0;
         if (!link_active) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            match_cnt <= '0;
            slip_pend <= 1'b0;
            rx_locked <= 1'b0;
         end else begin
            sr <= frame_word;
            // A slip is one held count, which stretches the next frame to R+1 bits.
            if (slip_pend) slip_pend <= 1'b0;
            else           bit_cnt   <= bit_cnt + PW'(1);

            case (state)
               IDLE: begin
                  state     <= TRAIN;
                  match_cnt <= '0;
               end
               TRAIN: begin
                  if (realign) begin
                     match_cnt <= '0;
                  end else if (boundary) begin
                     if (frame_word == pTRAIN_PATTERN) begin
                        if (match_cnt + 8'd1 >= LOCK_MAX) begin
                           match_cnt <= LOCK_MAX;
                           state     <= LOCKED;
                           rx_locked <= 1'b1;
                        end else begin
                           match_cnt <= match_cnt + 8'd1;
                        end
                     end else begin
                        match_cnt <= '0;
                        slip_pend <= 1'b1;
                        rx_phase  <= rx_phase + PW'(1);
                     end
                  end
               end
               LOCKED: begin
                  if (realign) begin
                     state     <= TRAIN;
                     match_cnt <= '0;
                     rx_locked <= 1'b0;
                  end else if (boundary) begin
                     rxdata_out   <= frame_word;
                     rxdata_valid <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fsic_io_serdes_rx.sv
// Directed bench for fsic_io_serdes_rx: drives LSB-first serial words and checks
// lock, slip phase, recovered data, valid spacing, link drop, realign and async reset.
module tb_fsic_io_serdes_rx;

   logic       ioclk = 1'b0;
   logic       axis_rst_n = 1'b0;
   logic       serial_data_in = 1'b0;
   logic       link_active = 1'b0;
   logic       realign = 1'b0;
   logic [3:0] rxdata_out;
   logic       rxdata_valid;
   logic       rx_locked;
   logic [1:0] rx_phase;

   int pass_cnt  = 0;
   int check_cnt = 0;
   int cyc       = 0;
   int         valid_cyc[$];
   logic [3:0] valid_word[$];

   fsic_io_serdes_rx #(
      .pCLK_RATIO     (4),
      .pTRAIN_PATTERN (4'b0001),
      .pLOCK_CNT      (4)
   ) dut (
      .ioclk          (ioclk),
      .axis_rst_n     (axis_rst_n),
      .serial_data_in (serial_data_in),
      .link_active    (link_active),
      .realign        (realign),
      .rxdata_out     (rxdata_out),
      .rxdata_valid   (rxdata_valid),
      .rx_locked      (rx_locked),
      .rx_phase       (rx_phase)
   );

   always #5 ioclk = ~ioclk;

   always @(posedge ioclk) cyc++;

   // Record every valid pulse (sampled mid-cycle) with its cycle number.
   always @(negedge ioclk) begin
      if (rxdata_valid === 1'b1) begin
         valid_cyc.push_back(cyc);
         valid_word.push_back(rxdata_out);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // One serial bit: inputs change on the falling edge, outputs are looked at 1ns after the rising edge.
   task automatic send_bit(input logic b, input logic la = 1'b1, input logic ra = 1'b0);
      @(negedge ioclk);
      serial_data_in = b;
      link_active    = la;
      realign        = ra;
      @(posedge ioclk);
      #1;
      realign = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w);
      for (int i = 0; i < 4; i++) send_bit(w[i]);
   endtask

   task automatic test_reset;
      #1;
      check_cnt++;
      if ({rxdata_out, rxdata_valid, rx_locked, rx_phase} !== 8'h00) begin
         $display("FAIL reset_outputs: got out=%h valid=%b locked=%b phase=%0d, expected all 0",
                  rxdata_out, rxdata_valid, rx_locked, rx_phase);
      end else pass_cnt++;
      repeat (3) @(negedge ioclk);
      axis_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) send_bit(i[0], 1'b0, (i == 3));
      send_bit(1'b0, 1'b0);
      check_cnt++;
      if (rx_locked !== 1'b0) $display("FAIL idle_locked: got %b expected 0", rx_locked);
      else pass_cnt++;
      check_cnt++;
      if (valid_cyc.size() !== 0) $display("FAIL idle_valid: got %0d pulses expected 0", valid_cyc.size());
      else pass_cnt++;
   endtask

   task automatic test_aligned_lock;
      repeat (3) send_word(4'b0001);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
      check_cnt++;
      if (rx_locked !== 1'b0) $display("FAIL aligned_early_lock: got %b expected 0", rx_locked);
      else pass_cnt++;
      send_bit(1'b0);
      check_cnt++;
      if (rx_locked !== 1'b1) $display("FAIL aligned_lock: got %b expected 1", rx_locked);
      else pass_cnt++;
      check_cnt++;
      if (rx_phase !== 2'd0) $display("FAIL aligned_phase: got %0d expected 0", rx_phase);
      else pass_cnt++;
      send_word(4'h3);
      check_cnt++;
      if (rxdata_valid !== 1'b1 || rxdata_out !== 4'h3)
         $display("FAIL aligned_data: got valid=%b out=%h expected valid=1 out=3", rxdata_valid, rxdata_out);
      else pass_cnt++;
   endtask

   task automatic test_link_drop;
      int n;
      send_bit(1'b0, 1'b0);
      check_cnt++;
      if (rx_locked !== 1'b0 || rxdata_valid !== 1'b0)
         $display("FAIL drop_locked: got locked=%b valid=%b expected 0 0", rx_locked, rxdata_valid);
      else pass_cnt++;
      check_cnt++;
      if (rxdata_out !== 4'h3) $display("FAIL drop_retain: got out=%h expected 3", rxdata_out);
      else pass_cnt++;
      n = valid_cyc.size();
      repeat (4) send_bit(1'b1, 1'b0);
      repeat (4) send_word(4'b0001);
      check_cnt++;
      if (valid_cyc.size() !== n) $display("FAIL drop_valid: got %0d pulses expected %0d", valid_cyc.size(), n);
      else pass_cnt++;
      check_cnt++;
      if (rx_locked !== 1'b1 || rx_phase !== 2'd0)
         $display("FAIL drop_relock: got locked=%b phase=%0d expected 1 0", rx_locked, rx_phase);
      else pass_cnt++;
   endtask

   task automatic test_misaligned;
      send_bit(1'b0, 1'b0);
      send_bit(1'b0); send_bit(1'b0);
      repeat (5) send_word(4'b0001);
      check_cnt++;
      if (rx_locked !== 1'b0 || rx_phase !== 2'd2)
         $display("FAIL misalign_pre: got locked=%b phase=%0d expected 0 2", rx_locked, rx_phase);
      else pass_cnt++;
      send_word(4'b0001);
      check_cnt++;
      if (rx_locked !== 1'b1 || rx_phase !== 2'd2)
         $display("FAIL misalign_lock: got locked=%b phase=%0d expected 1 2", rx_locked, rx_phase);
      else pass_cnt++;
   endtask

   task automatic test_data;
      int n;
      n = valid_cyc.size();
      send_word(4'hA);
      check_cnt++;
      if (rxdata_valid !== 1'b1 || rxdata_out !== 4'hA)
         $display("FAIL data_a: got valid=%b out=%h expected 1 a", rxdata_valid, rxdata_out);
      else pass_cnt++;
      send_bit(1'b1);
      check_cnt++;
      if (rxdata_valid !== 1'b0 || rxdata_out !== 4'hA)
         $display("FAIL data_hold: got valid=%b out=%h expected 0 a", rxdata_valid, rxdata_out);
      else pass_cnt++;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      check_cnt++;
      if (rxdata_valid !== 1'b1 || rxdata_out !== 4'h5)
         $display("FAIL data_5: got valid=%b out=%h expected 1 5", rxdata_valid, rxdata_out);
      else pass_cnt++;
      send_word(4'hF);
      check_cnt++;
      if (rxdata_valid !== 1'b1 || rxdata_out !== 4'hF)
         $display("FAIL data_f: got valid=%b out=%h expected 1 f", rxdata_valid, rxdata_out);
      else pass_cnt++;
      send_bit(1'b1);
      check_cnt++;
      if (valid_cyc.size() !== n + 3)
         $display("FAIL data_count: got %0d pulses expected %0d", valid_cyc.size(), n + 3);
      else begin
         pass_cnt++;
         check_cnt++;
         if (valid_cyc[n+1] - valid_cyc[n] !== 4 || valid_cyc[n+2] - valid_cyc[n+1] !== 4)
            $display("FAIL data_spacing: got gaps %0d %0d expected 4 4",
                     valid_cyc[n+1] - valid_cyc[n], valid_cyc[n+2] - valid_cyc[n+1]);
         else pass_cnt++;
         check_cnt++;
         if (valid_word[n] !== 4'hA || valid_word[n+1] !== 4'h5 || valid_word[n+2] !== 4'hF)
            $display("FAIL data_seq: got %h %h %h expected a 5 f", valid_word[n], valid_word[n+1], valid_word[n+2]);
         else pass_cnt++;
      end
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
      check_cnt++;
      if (rxdata_valid !== 1'b1 || rxdata_out !== 4'h9)
         $display("FAIL data_9: got valid=%b out=%h expected 1 9", rxdata_valid, rxdata_out);
      else pass_cnt++;
   endtask

   task automatic test_realign;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
      send_bit(1'b0, 1'b1, 1'b1);
      check_cnt++;
      if (rxdata_valid !== 1'b0 || rx_locked !== 1'b0)
         $display("FAIL realign_boundary: got valid=%b locked=%b expected 0 0", rxdata_valid, rx_locked);
      else pass_cnt++;
      check_cnt++;
      if (rxdata_out !== 4'h9 || rx_phase !== 2'd2)
         $display("FAIL realign_retain: got out=%h phase=%0d expected 9 2", rxdata_out, rx_phase);
      else pass_cnt++;
      repeat (3) send_word(4'b0001);
      check_cnt++;
      if (rx_locked !== 1'b0) $display("FAIL realign_early: got locked=%b expected 0", rx_locked);
      else pass_cnt++;
      send_word(4'b0001);
      check_cnt++;
      if (rx_locked !== 1'b1 || rx_phase !== 2'd2)
         $display("FAIL realign_relock: got locked=%b phase=%0d expected 1 2", rx_locked, rx_phase);
      else pass_cnt++;
      send_word(4'hC);
      check_cnt++;
      if (rxdata_valid !== 1'b1 || rxdata_out !== 4'hC)
         $display("FAIL realign_data: got valid=%b out=%h expected 1 c", rxdata_valid, rxdata_out);
      else pass_cnt++;
   endtask

   task automatic test_async_reset;
      @(negedge ioclk);
      #2;
      axis_rst_n = 1'b0;
      #1;
      check_cnt++;
      if ({rxdata_out, rxdata_valid, rx_locked, rx_phase} !== 8'h00)
         $display("FAIL async_reset: got out=%h valid=%b locked=%b phase=%0d expected all 0",
                  rxdata_out, rxdata_valid, rx_locked, rx_phase);
      else pass_cnt++;
      link_active = 1'b0;
      @(negedge ioclk);
      axis_rst_n = 1'b1;
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      check_cnt++;
      if (rx_locked !== 1'b0 || rxdata_valid !== 1'b0)
         $display("FAIL post_reset_idle: got locked=%b valid=%b expected 0 0", rx_locked, rxdata_valid);
      else pass_cnt++;
   endtask

   task automatic test_corrupted;
      repeat (3) send_word(4'b0001);
      send_word(4'b0011);
      check_cnt++;
      if (rx_locked !== 1'b0 || rx_phase !== 2'd1)
         $display("FAIL corrupt_slip: got locked=%b phase=%0d expected 0 1", rx_locked, rx_phase);
      else pass_cnt++;
      repeat (6) send_word(4'b0001);
      check_cnt++;
      if (rx_locked !== 1'b0 || rx_phase !== 2'd0)
         $display("FAIL corrupt_search: got locked=%b phase=%0d expected 0 0", rx_locked, rx_phase);
      else pass_cnt++;
      send_word(4'b0001);
      check_cnt++;
      if (rx_locked !== 1'b0) $display("FAIL corrupt_early: got locked=%b expected 0", rx_locked);
      else pass_cnt++;
      send_word(4'b0001);
      check_cnt++;
      if (rx_locked !== 1'b1 || rx_phase !== 2'd0)
         $display("FAIL corrupt_lock: got locked=%b phase=%0d expected 1 0", rx_locked, rx_phase);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_aligned_lock();
      test_link_drop();
      test_misaligned();
      test_data();
      test_realign();
      test_async_reset();
      test_corrupted();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
